// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the sequential unsigned multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_32bits.sv
// Shared 32-bit adder/subtractor; Ctr=1 subtracts, and Co=1 then means no borrow.
module adder_32bits
  import muldiv_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ctr,
  output logic [W-1:0] S,
  output logic         Co
);

  logic [W:0] sum;

  // Subtract as A + ~B + 1 so the carry-out doubles as the not-borrow flag.
  assign sum     = {1'b0, A} + {1'b0, B ^ {W{Ctr}}} + (W + 1)'(Ctr);
  assign {Co, S} = sum;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer: 32 shift-add or restoring shift-subtract
// iterations through one shared adder, results left in hi/lo.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   rem_shift;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_s;
  logic               add_co;
  logic               mul_c;
  logic [WIDTH-1:0]   mul_s;
  logic               take;

  // Divide shifts the next dividend bit into the partial remainder before subtracting.
  assign rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign add_a     = (op_q == OP_DIV) ? rem_shift : hi_q;

  adder_32bits u_adder (
    .A   (add_a),
    .B   (opnd_q),
    .Ctr (op_q),
    .S   (add_s),
    .Co  (add_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    mul_c   = 1'b0;
    mul_s   = hi_q;
    take    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          opnd_d = b;
          cnt_d  = '0;
          dz_d   = 1'b0;
          if (op == OP_DIV && b == '0) begin
            hi_d    = a;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = a;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (op_q == OP_MUL) begin
          if (lo_q[0]) begin
            mul_c = add_co;
            mul_s = add_s;
          end
          hi_d = {mul_c, mul_s[WIDTH-1:1]};
          lo_d = {mul_s[0], lo_q[WIDTH-1:1]};
        end else begin
          // A set hi[31] means the true remainder exceeds any 32-bit divisor.
          take = hi_q[WIDTH-1] | add_co;
          hi_d = take ? add_s : rem_shift;
          lo_d = {lo_q[WIDTH-2:0], take};
        end
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int n_assert;
  int n_fail;

  muldiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from 64-bit arithmetic.
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    logic [63:0] p;
    if (o == 1'b0) begin
      p  = {32'd0, x} * {32'd0, y};
      eh = p[63:32];
      el = p[31:0];
      ed = 1'b0;
    end else if (y == 32'd0) begin
      eh = x;
      el = 32'hFFFF_FFFF;
      ed = 1'b1;
    end else begin
      eh = x % y;
      el = x / y;
      ed = 1'b0;
    end
  endtask

  // One full operation; inject>0 pulses a stray start in that busy cycle.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input int inject);
    logic [31:0] eh, el;
    logic        ed;
    int          lat;
    model(o, x, y, eh, el, ed);
    lat = (o == 1'b1 && y == 32'd0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == inject) begin
        start = 1'b1; op = 1'b1; a = $urandom; b = 32'd0;
      end else begin
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
      end
      check("busy_active", 32'(busy), 32'd1);
      check("done_timing", 32'(done), 32'(k == lat));
    end
    check("hi_result", hi, eh);
    check("lo_result", lo, el);
    check("div_zero", 32'(div_zero), 32'(ed));
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    check("done_idle", 32'(done), 32'd0);
    check("hi_hold", hi, eh);
    check("lo_hold", lo, el);
    check("dz_hold", 32'(div_zero), 32'(ed));
  endtask

  // Start an operation and pull reset in the given busy cycle.
  task automatic run_abort(input logic o, input logic [31:0] x, input logic [31:0] y, input int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= cyc; k++) @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    run_op(1'b0, 32'd7, 32'd6, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'h8000_0000, 32'd3, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(1'b1, 32'd5, 32'd0, 0);
    run_op(1'b0, 32'd3, 32'd3, 0);
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    run_abort(1'b1, 32'hDEAD_BEEF, 32'd13, 20);
    run_op(1'b1, 32'hDEAD_BEEF, 32'd13, 0);
    run_op(1'b0, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 32'd3, 32'd7, 0);

    for (int i = 0; i < 30; i++) begin
      logic        o;
      logic [31:0] x, y;
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        default: y = $urandom;
      endcase
      run_op(o, x, y, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle unsigned multiply/divide sequencer for the multicycle CPU datapath. It time-shares one 32-bit ripple adder/subtractor across 32 iterations: shift-add for MULTU and restoring shift-subtract for DIVU. Results land in HI/LO-style output registers. It sits beside the ALU and is started by the micro-control unit, which stalls on `busy`.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported because the shared adder is fixed at 32 bits.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = unsigned multiply, 1 = unsigned divide; sampled with `start`.
- `a`  in  32  multiplicand / dividend; sampled with `start`.
- `b`  in  32  multiplier / divisor; sampled with `start`.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `hi`  out  32  product[63:32] / remainder.
- `lo`  out  32  product[31:0] / quotient.
- `div_zero`  out  1  set when a divide had `b == 0`; cleared on the next accepted start.

## Operation
- States: IDLE, CALC, DONE. A 6-bit iteration counter `cnt` counts 0..31.
- IDLE + `start` with `op = 0`: latch `b` into the operand register, set `hi = 0`, `lo = a`, `cnt = 0`, go to CALC.
- IDLE + `start` with `op = 1`, `b != 0`: same loading as multiply, go to CALC.
- IDLE + `start` with `op = 1`, `b == 0`: set `hi = a`, `lo = 32'hFFFFFFFF`, `div_zero = 1`, go directly to DONE.
- Multiply iteration, adder in add mode (`Ctr = 0`), inputs `hi` and the operand register:
  - if `lo[0]`, form `{c, s} = {Co, S}`; otherwise `{c, s} = {0, hi}`.
  - update `{hi, lo} <= {c, s, lo} >> 1`, dropping the LSB.
- Divide iteration, adder in subtract mode (`Ctr = 1`):
  - form `r = {hi[30:0], lo[31]}` and compute `d = r - operand`.
  - `take = hi[31] | Co`, where `Co = 1` means no borrow.
  - update `hi <= take ? d : r` and `lo <= {lo[30:0], take}`.
- CALC: one iteration per cycle. After the iteration with `cnt == 31`, go to DONE; otherwise increment `cnt`.
- DONE: assert `done` for exactly one cycle, then return to IDLE.
- `hi`, `lo` and `div_zero` hold their values until the next accepted start.
- `start` while not in IDLE is ignored. No queuing.
- Operands are registered at start; `a` and `b` may change freely afterwards.

## Timing
- Reset values: state IDLE, `cnt = 0`, and `busy`, `done`, `hi`, `lo`, `div_zero` all 0.
- Reset asserted mid-operation aborts immediately; no `done` pulse is issued.
- With `start` sampled at edge T0:
  - CALC occupies cycles T0+1 .. T0+32.
  - DONE (`done = 1`, results valid) is cycle T0+33.
  - IDLE resumes at T0+34; a new start is accepted at the T0+34 edge at the earliest.
- Divide by zero: DONE at T0+1, IDLE at T0+2.
- `busy` rises the cycle after the start edge and falls when DONE exits.
- `hi`/`lo` change every CALC cycle; intermediate values are not meaningful.
- The critical path is the 32-bit ripple carry plus the result mux, one adder pass per cycle.

## Structure
- Package `muldiv_pkg` holds:
  - state encoding (`S_IDLE = 2'd0`, `S_CALC = 2'd1`, `S_DONE = 2'd2`);
  - `OP_MUL = 1'b0`, `OP_DIV = 1'b1`;
  - `ITER = 32`.
- Exactly one sub-module instance: `adder_32bits` (ports A, B, Ctr, S, Co), driven by `hi`/`r`, the operand register, and `Ctr = op`.
- No second adder, and no `*` or `/` operators.

## Test plan
- Multiply 7 × 6 → `done` at T0+33 with `hi = 0`, `lo = 42`, `div_zero = 0`; `busy` high T0+1..T0+33.
- Multiply `32'hFFFFFFFF × 32'hFFFFFFFF` → `hi = 32'hFFFFFFFE`, `lo = 32'h00000001`; exercises the carry-out path.
- Divide 100 / 7 → `lo = 14`, `hi = 2`. Divide `32'h80000000 / 3` → `lo = 32'h2AAAAAAA`, `hi = 2`.
- Divide `32'hFFFFFFFF / 32'h80000001` → `lo = 1`, `hi = 32'h7FFFFFFE`; exercises the `hi[31]` take path.
- Divide 5 / 0 → `done` at T0+1 with `hi = 5`, `lo = 32'hFFFFFFFF`, `div_zero = 1`. A following multiply 3 × 3 must clear `div_zero` and give `lo = 9`.
- Pulse `start` at cycle 10 of a busy multiply → ignored and the result is unchanged. Assert `rst_n = 0` at cycle 20 of another operation → all outputs 0 immediately and no `done` pulse; the next start runs normally.
